// File: rtl/rf_pkg.sv
// Shared defaults and port-slice helpers for the multi-port register file.
package rf_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_ABITS    = 5;
  localparam int DEF_NRD      = 2;
  localparam int DEF_NWR      = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_ZERO_REG = 1;

  // Lowest bit of port idx inside a flattened bus of w-bit fields.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

  // True when an address maps onto an implemented register.
  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: reserve sets a bit, any enabled write clears it,
// and a reserve beats a write to the same register in the same cycle.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ABITS    = DEF_ABITS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsv_en,
  input  logic [ABITS-1:0]     rsv_addr,
  input  logic [NWR*ABITS-1:0] wa,
  input  logic [NWR-1:0]       we,
  input  logic [NRD*ABITS-1:0] ra,
  output logic [NRD-1:0]       rd_busy
);

  logic [DEPTH-1:0] busy;
  logic             rsv_ok;

  // A reserve is only honoured for implemented, non-hardwired registers.
  always_comb begin
    rsv_ok = rsv_en && addr_in_range(int'(rsv_addr), DEPTH) &&
             !(ZERO_REG != 0 && rsv_addr == '0);
  end

  // Clears from writes are applied first so a same-cycle reserve overrides them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && addr_in_range(int'(wa[slice_lo(i, ABITS) +: ABITS]), DEPTH))
          busy[wa[slice_lo(i, ABITS) +: ABITS]] <= 1'b0;
      end
      if (rsv_ok)
        busy[rsv_addr] <= 1'b1;
    end
  end

  // Busy lookup reflects only the registered vector, never this cycle's reserve.
  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NRD; r++) begin
      if (addr_in_range(int'(ra[slice_lo(r, ABITS) +: ABITS]), DEPTH))
        rd_busy[r] = busy[ra[slice_lo(r, ABITS) +: ABITS]];
    end
  end

endmodule

// File: rtl/mp_register_file.sv
// Multi-port register file with optional write-to-read bypass, hardwired
// zero register, write-conflict flag and a busy-bit scoreboard.
module mp_register_file
  import rf_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ABITS    = DEF_ABITS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*ABITS-1:0] ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR*ABITS-1:0] wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [NWR-1:0]       we,
  input  logic                 rsv_en,
  input  logic [ABITS-1:0]     rsv_addr,
  output logic                 wr_conflict
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [NWR-1:0]              wr_ok;
  logic                        conflict_now;

  // A write only lands on an implemented register that is not hardwired zero.
  always_comb begin
    wr_ok = '0;
    for (int i = 0; i < NWR; i++) begin
      wr_ok[i] = we[i] &&
                 addr_in_range(int'(wa[slice_lo(i, ABITS) +: ABITS]), DEPTH) &&
                 !(ZERO_REG != 0 && wa[slice_lo(i, ABITS) +: ABITS] == '0);
    end
  end

  // Any two enabled write ports aiming at the same address form a conflict.
  always_comb begin
    conflict_now = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (we[i] && we[j] &&
            wa[slice_lo(i, ABITS) +: ABITS] == wa[slice_lo(j, ABITS) +: ABITS])
          conflict_now = 1'b1;
      end
    end
  end

  // Ports are applied in ascending order so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_ok[i])
          regs[wa[slice_lo(i, ABITS) +: ABITS]] <= wd[slice_lo(i, WIDTH) +: WIDTH];
      end
      wr_conflict <= conflict_now;
    end
  end

  // Zero-latency reads; bypass scans ascending so the highest write port wins.
  always_comb begin
    logic [ABITS-1:0] addr;
    logic [WIDTH-1:0] val;
    rd   = '0;
    addr = '0;
    val  = '0;
    for (int r = 0; r < NRD; r++) begin
      addr = ra[slice_lo(r, ABITS) +: ABITS];
      val  = '0;
      if (addr_in_range(int'(addr), DEPTH) && !(ZERO_REG != 0 && addr == '0))
        val = regs[addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && wa[slice_lo(j, ABITS) +: ABITS] == addr)
            val = wd[slice_lo(j, WIDTH) +: WIDTH];
        end
      end
      rd[slice_lo(r, WIDTH) +: WIDTH] = val;
    end
  end

  rf_scoreboard #(
    .DEPTH   (DEPTH),
    .ABITS   (ABITS),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .wa      (wa),
    .we      (we),
    .ra      (ra),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_mp_register_file.sv
// Scoreboard bench for mp_register_file: one bypassing and one non-bypassing
// instance share stimulus; expectations are queued and checked by a monitor.
module tb_mp_register_file;
  import rf_pkg::*;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  // Which DUT output an expectation refers to.
  localparam int K_RD      = 0;
  localparam int K_RD_NB   = 1;
  localparam int K_BUSY    = 2;
  localparam int K_CONF    = 3;
  localparam int K_CONF_NB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*A-1:0] ra = '0;
  logic [NR*W-1:0] rd, rd_nb;
  logic [NR-1:0]   rd_busy, rd_busy_nb;
  logic [NW*A-1:0] wa = '0;
  logic [NW*W-1:0] wd = '0;
  logic [NW-1:0]   we = '0;
  logic            rsv_en = 1'b0;
  logic [A-1:0]    rsv_addr = '0;
  logic            wr_conflict, wr_conflict_nb;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  mp_register_file dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rd_busy(rd_busy),
    .wa(wa), .wd(wd), .we(we), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict)
  );

  mp_register_file #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_nb), .rd_busy(rd_busy_nb),
    .wa(wa), .wd(wd), .we(we), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .wr_conflict(wr_conflict_nb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Advance to just after the next edge and return all strobes to idle.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    we     = '0;
    rsv_en = 1'b0;
  endtask

  task automatic drive_wr(input int p, input int addr, input logic [31:0] data);
    logic [A-1:0] a;
    a = A'(addr);
    we[p]          = 1'b1;
    wa[p*A +: A]   = a;
    wd[p*W +: W]   = data;
  endtask

  task automatic drive_rd(input int p, input int addr);
    logic [A-1:0] a;
    a = A'(addr);
    ra[p*A +: A] = a;
  endtask

  task automatic drive_rsv(input int addr);
    rsv_en   = 1'b1;
    rsv_addr = A'(addr);
  endtask

  task automatic expect_out(input string name, input int kind, input int port,
                            input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.exp  = v;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic check_output(input exp_t e);
    logic [31:0] act;
    case (e.kind)
      K_RD:      act = rd[e.port*W +: W];
      K_RD_NB:   act = rd_nb[e.port*W +: W];
      K_BUSY:    act = {31'b0, rd_busy[e.port]};
      K_CONF:    act = {31'b0, wr_conflict};
      default:   act = {31'b0, wr_conflict_nb};
    endcase
    n_cmp++;
    if (e.cyc != cyc) begin
      n_bad++;
      $display("[TB] FAIL %s: checked in cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
    end else if (act !== e.exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", e.name, act, e.exp);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, so compare everything due by now.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc)
        check_output(sb.pop_front());
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    apply_stimulus();
    apply_stimulus();

    // Reset state.
    rst_n = 1'b1;
    drive_rd(0, 3);
    drive_rd(1, 0);
    expect_out("reset_rd0", K_RD, 0, 32'h0);
    expect_out("reset_rd1", K_RD, 1, 32'h0);
    expect_out("reset_busy0", K_BUSY, 0, 32'h0);
    expect_out("reset_conf", K_CONF, 0, 32'h0);

    // Basic write then read.
    apply_stimulus();
    drive_wr(0, 3, 32'hDEADBEEF);
    drive_rd(0, 3);
    expect_out("wr3_bypass", K_RD, 0, 32'hDEADBEEF);
    expect_out("wr3_nobypass_old", K_RD_NB, 0, 32'h0);
    apply_stimulus();
    expect_out("rd3", K_RD, 0, 32'hDEADBEEF);
    expect_out("rd3_nb", K_RD_NB, 0, 32'hDEADBEEF);

    // Bypass on port 1, with both read ports on the same address.
    apply_stimulus();
    drive_wr(1, 7, 32'h12345678);
    drive_rd(0, 7);
    drive_rd(1, 7);
    expect_out("byp7_rd1", K_RD, 1, 32'h12345678);
    expect_out("byp7_rd0_same", K_RD, 0, 32'h12345678);
    expect_out("byp7_nb_old", K_RD_NB, 1, 32'h0);
    apply_stimulus();
    expect_out("rd7", K_RD, 1, 32'h12345678);
    expect_out("rd7_nb", K_RD_NB, 1, 32'h12345678);

    // Write conflict: highest port wins, flag one cycle late for one cycle.
    apply_stimulus();
    drive_wr(0, 9, 32'hAAAA0000);
    drive_wr(1, 9, 32'h5555FFFF);
    drive_rd(0, 9);
    expect_out("conf_byp_prio", K_RD, 0, 32'h5555FFFF);
    expect_out("conf_same_cycle", K_CONF, 0, 32'h0);
    apply_stimulus();
    expect_out("reg9", K_RD, 0, 32'h5555FFFF);
    expect_out("reg9_nb", K_RD_NB, 0, 32'h5555FFFF);
    expect_out("conf_flag", K_CONF, 0, 32'h1);
    expect_out("conf_flag_nb", K_CONF_NB, 0, 32'h1);
    apply_stimulus();
    expect_out("conf_drop", K_CONF, 0, 32'h0);

    // Zero register, including the bypass cycle.
    apply_stimulus();
    drive_wr(0, 0, 32'hFFFFFFFF);
    drive_rd(0, 0);
    expect_out("zero_byp", K_RD, 0, 32'h0);
    apply_stimulus();
    expect_out("zero_after", K_RD, 0, 32'h0);
    expect_out("zero_after_nb", K_RD_NB, 0, 32'h0);

    // Scoreboard: reserve, clear by write, reserve beats write.
    apply_stimulus();
    drive_rsv(4);
    drive_rd(0, 4);
    drive_rd(1, 4);
    expect_out("rsv_no_bypass", K_BUSY, 0, 32'h0);
    apply_stimulus();
    expect_out("rsv4_busy0", K_BUSY, 0, 32'h1);
    expect_out("rsv4_busy1", K_BUSY, 1, 32'h1);
    apply_stimulus();
    drive_wr(0, 4, 32'h00000044);
    expect_out("clr4_pending", K_BUSY, 0, 32'h1);
    apply_stimulus();
    expect_out("clr4_done", K_BUSY, 0, 32'h0);
    apply_stimulus();
    drive_rsv(4);
    drive_wr(1, 4, 32'h00000055);
    expect_out("rsvwr4_pending", K_BUSY, 0, 32'h0);
    apply_stimulus();
    expect_out("rsvwr4_busy", K_BUSY, 0, 32'h1);
    expect_out("rsvwr4_data", K_RD, 0, 32'h00000055);

    // Reset mid-write and mid-reserve: everything is lost.
    apply_stimulus();
    drive_rsv(10);
    apply_stimulus();
    rst_n = 1'b0;
    drive_wr(0, 5, 32'h0000AAAA);
    drive_wr(1, 6, 32'h0000BBBB);
    drive_rsv(12);
    apply_stimulus();
    rst_n = 1'b1;
    drive_rd(0, 5);
    drive_rd(1, 6);
    expect_out("rst_rd5", K_RD, 0, 32'h0);
    expect_out("rst_rd6", K_RD, 1, 32'h0);
    expect_out("rst_busy6", K_BUSY, 1, 32'h0);
    apply_stimulus();
    drive_rd(0, 10);
    drive_rd(1, 12);
    expect_out("rst_busy10", K_BUSY, 0, 32'h0);
    expect_out("rst_busy12", K_BUSY, 1, 32'h0);
    apply_stimulus();
    drive_rd(0, 3);
    drive_rd(1, 4);
    expect_out("rst_rd3", K_RD, 0, 32'h0);
    expect_out("rst_rd4", K_RD, 1, 32'h0);
    expect_out("rst_busy4", K_BUSY, 1, 32'h0);
    expect_out("rst_conf", K_CONF, 0, 32'h0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mp_register_file.md
MP_REGISTER_FILE -- requirements
Module: mp_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..256).
REQ-003 SHALL have parameter ABITS, default 5, address width, equal to $clog2(DEPTH).
REQ-004 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter NWR, default 2, number of write ports (1..4).
REQ-006 SHALL have parameter BYPASS, default 1, where 1 forwards same-cycle write data to reads.
REQ-007 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-008 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-009 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- ra, in, NRD*ABITS, read addresses; port i occupies slice i.
- rd, out, NRD*WIDTH, read data; port i occupies slice i.
- rd_busy, out, NRD, scoreboard busy bit of each read address.
- wa, in, NWR*ABITS, write addresses.
- wd, in, NWR*WIDTH, write data.
- we, in, NWR, per-port write enables.
- rsv_en, in, 1, reserve request for the scoreboard.
- rsv_addr, in, ABITS, register to reserve.
- wr_conflict, out, 1, registered flag for a same-address multi-write.

Function
REQ-010 SHALL update register wa[i] with wd[i] at the rising clk when we[i]=1 and rst_n=1.
REQ-011 SHALL produce rd combinationally with zero-cycle read latency.
REQ-012 SHALL, with BYPASS=1, return wd[j] on rd[i] when we[j]=1 and wa[j]=ra[i] in the same cycle; otherwise rd[i] is the stored value.
REQ-013 SHALL, with BYPASS=0, return the pre-edge stored value on rd[i] regardless of same-cycle writes.
REQ-014 SHALL, when several enabled write ports target one address, give priority to the highest port index for both storage and bypass.
REQ-015 SHALL raise wr_conflict for exactly the cycle after any same-address multi-write, and hold it low otherwise.
REQ-016 SHALL, with ZERO_REG=1, ignore writes to address 0, read address 0 as all zeros (also when bypassed), and never set its busy bit.
REQ-017 SHALL ignore writes to addresses >= DEPTH and read them as zero.
REQ-018 SHALL handle the scoreboard as follows:
- rsv_en=1 sets busy[rsv_addr] at the next edge.
- Any enabled write to an address clears its busy bit at the next edge.
- A simultaneous reserve and write to the same address leaves the bit set (reserve wins).
REQ-019 SHALL drive rd_busy[i] = busy[ra[i]] from the registered scoreboard, with no bypass of same-cycle reserves.
REQ-020 SHALL support any number of read ports on the same address with identical results.

Reset
REQ-021 SHALL, when rst_n=0 at a rising edge, clear all registers to 0, clear all busy bits, and set wr_conflict=0.
REQ-022 SHALL give reset priority over any write or reserve in the same cycle; that write or reserve is lost.
REQ-023 SHALL show all reads as 0 and rd_busy as 0 in the cycle after reset, unless a write is being bypassed.

Structure
REQ-024 SHALL take default parameter values and the port-slice helper functions from the shared package rf_pkg.
REQ-025 SHALL implement the scoreboard (busy vector, reserve/clear logic) as the sub-module rf_scoreboard; storage, bypass and conflict logic stay in mp_register_file.

Verification
REQ-026 SHALL cover a basic write then read: we=01, wa0=3, wd0=0xDEADBEEF; next cycle ra0=3 -> rd0=0xDEADBEEF.
REQ-027 SHALL cover bypass: BYPASS=1, we1=1, wa1=7, wd1=0x12345678, ra1=7 in the same cycle -> rd1=0x12345678; with BYPASS=0 -> the old value.
REQ-028 SHALL cover a write conflict: we=11, wa0=wa1=9, wd0=0xAAAA0000, wd1=0x5555FFFF -> reg9=0x5555FFFF and wr_conflict=1 for one cycle.
REQ-029 SHALL cover the zero register: write 0xFFFFFFFF to address 0 -> rd of address 0 = 0, including the bypass cycle.
REQ-030 SHALL cover the scoreboard: rsv_addr=4 -> next cycle rd_busy=1 for ra=4; write to 4 -> cleared next cycle; simultaneous reserve and write to 4 -> stays 1.
REQ-031 SHALL cover reset mid-write: rst_n=0 with we=11 to addresses 5 and 6 -> both read 0 and all busy bits 0 afterwards.
